// File: rtl/beam_align_pkg.sv
// -----------------------------------------------------------------------------
// beam_align_pkg
// Shared defaults and helpers for the programmable beam aligner.
//   - DEF_* localparams : default parameter values for the block
//   - delay_t           : delay field type at the default width
//   - midscale()        : offset-binary midscale code for a sample width
//   - max_delay()       : largest legal delay (samples) for a store depth
// -----------------------------------------------------------------------------
package beam_align_pkg;

    localparam int DEF_NBEAMS = 2;
    localparam int DEF_NCHAN  = 8;
    localparam int DEF_NSAMP  = 8;
    localparam int DEF_NBITS  = 5;
    localparam int DEF_DEPTH  = 10;
    localparam int DEF_DLY_W  = 8;

    typedef logic [DEF_DLY_W-1:0] delay_t;

    // Offset-binary zero: only the MSB of the sample is set.
    function automatic logic [31:0] midscale(input int nbits);
        return 32'd1 << (nbits - 1);
    endfunction

    // The window may reach back as far as the oldest stored word.
    function automatic int max_delay(input int depth, input int nsamp);
        return (depth - 1) * nsamp;
    endfunction

endpackage

// File: rtl/beam_delay_table.sv
// -----------------------------------------------------------------------------
// beam_delay_table
// Shadow and active delay tables with range check and deferred commit.
// Writes land in the shadow table; a commit request arms a pending flag and
// the shadow table (including any write in the same cycle) is copied to the
// active table on the next accepted word, so a window never mixes delays.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_wr/i_beam/i_chan/i_val  shadow delay write
//   i_commit           commit request (absorbed while already pending)
//   i_accept           a data word is being accepted this cycle
//   o_active           flattened active delays, entry (b*NCHAN+c)
//   o_applied          1-cycle flag: active table was updated at last edge
//   o_err              sticky: an illegal write was discarded
// -----------------------------------------------------------------------------
module beam_delay_table
    import beam_align_pkg::*;
#(
    parameter int NBEAMS = DEF_NBEAMS,
    parameter int NCHAN  = DEF_NCHAN,
    parameter int NSAMP  = DEF_NSAMP,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DLY_W  = DEF_DLY_W,
    parameter int BEAM_W = 1,
    parameter int CHAN_W = 3
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_wr,
    input  logic [BEAM_W-1:0]              i_beam,
    input  logic [CHAN_W-1:0]              i_chan,
    input  logic [DLY_W-1:0]               i_val,
    input  logic                           i_commit,
    input  logic                           i_accept,
    output logic [NBEAMS*NCHAN*DLY_W-1:0]  o_active,
    output logic                           o_applied,
    output logic                           o_err
);

    localparam logic [DLY_W-1:0] MAX_DLY = DLY_W'(max_delay(DEPTH, NSAMP));

    logic [DLY_W-1:0] r_shadow [NBEAMS][NCHAN];
    logic [DLY_W-1:0] r_active [NBEAMS][NCHAN];
    logic [DLY_W-1:0] w_shadow_nxt [NBEAMS][NCHAN];
    logic             r_pending;
    logic             r_applied;
    logic             r_err;
    logic             w_range_ok;
    logic             w_wr_ok;
    logic             w_pend;
    logic             w_apply;

    // Range check, merged shadow view and commit decision.
    always_comb begin
        w_range_ok   = (int'(i_beam) < NBEAMS) && (int'(i_chan) < NCHAN) &&
                       (i_val <= MAX_DLY);
        w_wr_ok      = i_wr && w_range_ok;
        w_shadow_nxt = r_shadow;
        if (w_wr_ok) begin
            w_shadow_nxt[i_beam][i_chan] = i_val;
        end else begin
            w_shadow_nxt = r_shadow;
        end
        // A fresh request while pending simply merges into the pending one.
        w_pend  = r_pending || i_commit;
        w_apply = w_pend && i_accept;
    end

    // Delay tables, pending flag, apply flag and sticky error.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int b = 0; b < NBEAMS; b++) begin
                for (int c = 0; c < NCHAN; c++) begin
                    r_shadow[b][c] <= '0;
                    r_active[b][c] <= '0;
                end
            end
            r_pending <= 1'b0;
            r_applied <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_shadow <= w_shadow_nxt;
            if (w_apply) begin
                r_active <= w_shadow_nxt;
            end
            r_pending <= w_pend && !i_accept;
            r_applied <= w_apply;
            if (i_wr && !w_range_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    for (genvar gb = 0; gb < NBEAMS; gb++) begin : g_beam
        for (genvar gc = 0; gc < NCHAN; gc++) begin : g_chan
            assign o_active[(gb*NCHAN+gc)*DLY_W +: DLY_W] = r_active[gb][gc];
        end
    end

    assign o_applied = r_applied;
    assign o_err     = r_err;

endmodule

// File: rtl/beam_align_prog.sv
// -----------------------------------------------------------------------------
// beam_align_prog
// Programmable per-beam/per-channel sample aligner. Each channel keeps the
// last DEPTH words in a flattened shift store (newest word at the top); each
// beam/channel output window is a fixed-width part-select reaching back by
// the active delay in samples.
// Optional feature macro: BEAM_ALIGN_READBACK_EN adds dly_rd_o, a registered
// readback of the active delay addressed by dly_beam_i/dly_chan_i.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   data_i/data_valid_i per-channel words, sample 0 (earliest) at the LSBs
//   dly_wr_i, dly_beam_i, dly_chan_i, dly_val_i  shadow delay write
//   dly_commit_i        request shadow-to-active copy
//   beams_o/valid_o     aligned windows, two cycles after acceptance
//   commit_done_o       pulse with the first output using new delays
//   dly_err_o           sticky illegal-write flag
//   dly_rd_o            (BEAM_ALIGN_READBACK_EN only) active delay readback
// -----------------------------------------------------------------------------
module beam_align_prog
    import beam_align_pkg::*;
#(
    parameter int NBEAMS = DEF_NBEAMS,
    parameter int NCHAN  = DEF_NCHAN,
    parameter int NSAMP  = DEF_NSAMP,
    parameter int NBITS  = DEF_NBITS,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DLY_W  = DEF_DLY_W,
    localparam int BEAM_W = (NBEAMS > 1) ? $clog2(NBEAMS) : 1,
    localparam int CHAN_W = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NCHAN*NSAMP*NBITS-1:0]         data_i,
    input  logic                                 data_valid_i,
    input  logic                                 dly_wr_i,
    input  logic [BEAM_W-1:0]                    dly_beam_i,
    input  logic [CHAN_W-1:0]                    dly_chan_i,
    input  logic [DLY_W-1:0]                     dly_val_i,
    input  logic                                 dly_commit_i,
    output logic [NBEAMS*NCHAN*NSAMP*NBITS-1:0]  beams_o,
    output logic                                 valid_o,
    output logic                                 commit_done_o,
`ifdef BEAM_ALIGN_READBACK_EN
    output logic [DLY_W-1:0]                     dly_rd_o,
`endif
    output logic                                 dly_err_o
);

    localparam int W      = NSAMP * NBITS;
    localparam int SW     = DEPTH * W;
    localparam int TOPW   = (DEPTH - 1) * W;
    localparam int OFF_W  = $clog2(SW);
    localparam int FILL_W = $clog2(DEPTH + 1) + 4;
    localparam logic [NBITS-1:0] MID = NBITS'(midscale(NBITS));

    logic [SW-1:0]                   r_store [NCHAN];
    logic [FILL_W-1:0]               r_fill;
    logic                            r_acc_d1;
    logic [NBEAMS*NCHAN*W-1:0]       r_beams;
    logic                            r_valid;
    logic                            r_commit_done;
    logic [NBEAMS*NCHAN*DLY_W-1:0]   w_active;
    logic                            w_applied;
    logic                            w_err;
    logic                            w_primed;
    logic [NBEAMS*NCHAN*W-1:0]       w_win;
    logic [OFF_W-1:0]                w_off;

    beam_delay_table #(
        .NBEAMS (NBEAMS),
        .NCHAN  (NCHAN),
        .NSAMP  (NSAMP),
        .DEPTH  (DEPTH),
        .DLY_W  (DLY_W),
        .BEAM_W (BEAM_W),
        .CHAN_W (CHAN_W)
    ) u_table (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_wr      (dly_wr_i),
        .i_beam    (dly_beam_i),
        .i_chan    (dly_chan_i),
        .i_val     (dly_val_i),
        .i_commit  (dly_commit_i),
        .i_accept  (data_valid_i),
        .o_active  (w_active),
        .o_applied (w_applied),
        .o_err     (w_err)
    );

    assign w_primed = (r_fill >= FILL_W'(DEPTH));

    // Per-channel sample store; shifts only on accepted words.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NCHAN; c++) begin
                for (int s = 0; s < DEPTH*NSAMP; s++) begin
                    r_store[c][s*NBITS +: NBITS] <= MID;
                end
            end
        end else if (data_valid_i) begin
            for (int c = 0; c < NCHAN; c++) begin
                r_store[c] <= {data_i[c*W +: W], r_store[c][SW-1:W]};
            end
        end
    end

    // Saturating count of accepted words since reset, and acceptance delay.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fill   <= '0;
            r_acc_d1 <= 1'b0;
        end else begin
            r_acc_d1 <= data_valid_i;
            if (data_valid_i && (r_fill < FILL_W'(DEPTH))) begin
                r_fill <= r_fill + FILL_W'(1);
            end
        end
    end

    // Window select: delay 0 is the newest word; each delay step moves the
    // window down by one sample towards older data.
    always_comb begin
        w_win = '0;
        w_off = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            for (int c = 0; c < NCHAN; c++) begin
                w_off = OFF_W'(TOPW) -
                        OFF_W'(NBITS) * OFF_W'(w_active[(b*NCHAN+c)*DLY_W +: DLY_W]);
                w_win[(b*NCHAN+c)*W +: W] = r_store[c][w_off +: W];
            end
        end
    end

    // Output registers: windows load once per accepted word after priming.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < NBEAMS*NCHAN*NSAMP; s++) begin
                r_beams[s*NBITS +: NBITS] <= MID;
            end
            r_valid       <= 1'b0;
            r_commit_done <= 1'b0;
        end else begin
            if (r_acc_d1 && w_primed) begin
                r_beams <= w_win;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
            // Active table changed at the acceptance edge, so this edge is
            // the first one registering a window with the new delays.
            r_commit_done <= w_applied;
        end
    end

`ifdef BEAM_ALIGN_READBACK_EN
    logic [DLY_W-1:0] r_dly_rd;

    // Registered readback of the addressed active delay.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dly_rd <= '0;
        end else begin
            r_dly_rd <= '0;
            for (int b = 0; b < NBEAMS; b++) begin
                for (int c = 0; c < NCHAN; c++) begin
                    if ((int'(dly_beam_i) == b) && (int'(dly_chan_i) == c)) begin
                        r_dly_rd <= w_active[(b*NCHAN+c)*DLY_W +: DLY_W];
                    end
                end
            end
        end
    end

    assign dly_rd_o = r_dly_rd;
`endif

    assign beams_o       = r_beams;
    assign valid_o       = r_valid;
    assign commit_done_o = r_commit_done;
    assign dly_err_o     = w_err;

endmodule

// File: tb/tb_beam_align_prog.sv
// -----------------------------------------------------------------------------
// tb_beam_align_prog
// Directed bench for beam_align_prog at default parameters. A reference model
// of the delay tables predicts each output window from the ramp stream and
// queues it with its due cycle; outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_beam_align_prog;
    import beam_align_pkg::*;

    localparam int NB  = 2;
    localparam int NC  = 8;
    localparam int NS  = 8;
    localparam int NBT = 5;
    localparam int DEP = 10;
    localparam int DW  = 8;
    localparam int W   = NS * NBT;
    localparam int BW  = NB * NC * W;
    localparam int MAXD = (DEP - 1) * NS;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [NC*W-1:0]   data_i;
    logic              data_valid_i;
    logic              dly_wr_i;
    logic [0:0]        dly_beam_i;
    logic [2:0]        dly_chan_i;
    logic [DW-1:0]     dly_val_i;
    logic              dly_commit_i;
    logic [BW-1:0]     beams_o;
    logic              valid_o;
    logic              commit_done_o;
    logic              dly_err_o;
`ifdef BEAM_ALIGN_READBACK_EN
    logic [DW-1:0]     dly_rd_o;
`endif

    beam_align_prog dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .data_i        (data_i),
        .data_valid_i  (data_valid_i),
        .dly_wr_i      (dly_wr_i),
        .dly_beam_i    (dly_beam_i),
        .dly_chan_i    (dly_chan_i),
        .dly_val_i     (dly_val_i),
        .dly_commit_i  (dly_commit_i),
        .beams_o       (beams_o),
        .valid_o       (valid_o),
        .commit_done_o (commit_done_o),
`ifdef BEAM_ALIGN_READBACK_EN
        .dly_rd_o      (dly_rd_o),
`endif
        .dly_err_o     (dly_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] beams;
        logic          cd;
        int            due;
    } exp_t;

    exp_t          q[$];
    delay_t        m_sh [NB][NC];
    delay_t        m_ac [NB][NC];
    bit            m_pend;
    int            m_fill;
    int            k;
    int            cyc;
    int            n_assert;
    int            n_fail;
    logic [BW-1:0] last;
    logic [BW-1:0] midw;

    task automatic chkw(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [BW-1:0] exp_beams(input int kk);
        logic [BW-1:0] r;
        int s;
        r = '0;
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < NC; c++)
                for (int j = 0; j < NS; j++) begin
                    s = kk*NS + j - int'(m_ac[b][c]);
                    r[((b*NC+c)*NS+j)*NBT +: NBT] = 5'(((s % 32) + 32) % 32);
                end
        return r;
    endfunction

    function automatic logic [NC*W-1:0] ramp_word(input int kk);
        logic [NC*W-1:0] r;
        for (int c = 0; c < NC; c++)
            for (int j = 0; j < NS; j++)
                r[(c*NS+j)*NBT +: NBT] = 5'((kk*NS + j) % 32);
        return r;
    endfunction

    // Check outputs of the last rising edge, then advance to just past the next.
    task automatic step();
        @(negedge clk);
        if (rst_i) begin
            last = midw;
            chk1("rst_valid", valid_o, 1'b0);
            chk1("rst_commit_done", commit_done_o, 1'b0);
            chkw("rst_beams", beams_o, last);
        end else if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk1("valid", valid_o, 1'b1);
            chkw("beams", beams_o, e.beams);
            chk1("commit_done", commit_done_o, e.cd);
            last = e.beams;
        end else begin
            chk1("idle_valid", valid_o, 1'b0);
            chk1("idle_commit_done", commit_done_o, 1'b0);
            chkw("hold_beams", beams_o, last);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < NC; c++) begin
                m_sh[b][c] = '0;
                m_ac[b][c] = '0;
            end
        m_pend = 1'b0;
        m_fill = 0;
        last   = midw;
    endtask

    task automatic drive_word();
        exp_t e;
        data_i       = ramp_word(k);
        data_valid_i = 1'b1;
        e.cd = 1'b0;
        if (m_pend) begin
            m_ac   = m_sh;
            m_pend = 1'b0;
            e.cd   = 1'b1;
        end
        if (m_fill < DEP) m_fill++;
        if (m_fill >= DEP) begin
            e.beams = exp_beams(k);
            e.due   = cyc + 2;
            q.push_back(e);
        end
        step();
        data_valid_i = 1'b0;
        k++;
    endtask

    task automatic wr_dly(input logic [0:0] b, input logic [2:0] c, input int v, input logic commit);
        dly_wr_i     = 1'b1;
        dly_beam_i   = b;
        dly_chan_i   = c;
        dly_val_i    = 8'(v);
        dly_commit_i = commit;
        if (v <= MAXD) m_sh[b][c] = delay_t'(v);
        if (commit) m_pend = 1'b1;
        step();
        dly_wr_i     = 1'b0;
        dly_commit_i = 1'b0;
    endtask

    task automatic commit_req();
        dly_commit_i = 1'b1;
        m_pend       = 1'b1;
        step();
        dly_commit_i = 1'b0;
    endtask

    task automatic do_reset();
        chk1("queue_drained_before_reset", (q.size() == 0), 1'b1);
        q.delete();
        rst_i = 1'b1;
        model_reset();
        step();
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        k        = 0;
        for (int s = 0; s < NB*NC*NS; s++) midw[s*NBT +: NBT] = 5'd16;
        rst_i        = 1'b1;
        data_i       = '0;
        data_valid_i = 1'b0;
        dly_wr_i     = 1'b0;
        dly_beam_i   = 1'b0;
        dly_chan_i   = 3'd0;
        dly_val_i    = 8'd0;
        dly_commit_i = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        step();
        step();
        rst_i = 1'b0;
        chk1("err_after_reset", dly_err_o, 1'b0);

        // Priming with ramp data, all delays zero.
        for (int i = 0; i < 12; i++) drive_word();
        step();
        step();

        // Beam 1 channel 3 delay 13.
        wr_dly(1'b1, 3'd3, 13, 1'b0);
        commit_req();
        for (int i = 0; i < 3; i++) drive_word();
        step();
        step();

        // Largest legal delay is accepted, one past it is rejected.
        wr_dly(1'b0, 3'd0, MAXD, 1'b0);
        chk1("err_max_legal", dly_err_o, 1'b0);
        wr_dly(1'b1, 3'd3, MAXD + 1, 1'b0);
        chk1("err_set", dly_err_o, 1'b1);
        commit_req();
        for (int i = 0; i < 2; i++) drive_word();
        step();
        chk1("err_sticky", dly_err_o, 1'b1);

        // Commit while input idles: nothing happens until the next word.
        wr_dly(1'b0, 3'd5, 40, 1'b0);
        commit_req();
        for (int i = 0; i < 5; i++) step();
        for (int i = 0; i < 2; i++) drive_word();
        step();
        step();

        // Write with commit, repeated commit, then a later write: one commit.
        wr_dly(1'b0, 3'd1, 8, 1'b1);
        commit_req();
        wr_dly(1'b1, 3'd0, MAXD, 1'b0);
        for (int i = 0; i < 3; i++) drive_word();
        step();
        step();

`ifdef BEAM_ALIGN_READBACK_EN
        wr_dly(1'b0, 3'd0, 7, 1'b1);
        drive_word();
        dly_beam_i = 1'b0;
        dly_chan_i = 3'd0;
        step();
        chk8("readback", dly_rd_o, 8'd7);
        step();
`endif

        // Reset while a commit is pending cancels it.
        wr_dly(1'b0, 3'd0, 20, 1'b0);
        commit_req();
        do_reset();
        chk1("err_cleared", dly_err_o, 1'b0);
        for (int i = 0; i < 12; i++) drive_word();
        step();
        step();
        step();
        chk1("queue_drained_at_end", (q.size() == 0), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/beam_align_prog.md
BEAM_ALIGN_PROG -- requirements
Module: beam_align_prog

Interface
REQ-001 SHALL have parameter NBEAMS, default 2, number of beams produced.
REQ-002 SHALL have parameter NCHAN, default 8, antenna channels.
REQ-003 SHALL have parameter NSAMP, default 8, samples per clock per channel.
REQ-004 SHALL have parameter NBITS, default 5, offset-binary sample width.
REQ-005 SHALL have parameter DEPTH, default 10, stored words per channel; legal range 2..32.
REQ-006 SHALL have parameter DLY_W, default 8, delay field width; must satisfy 2^DLY_W > (DEPTH-1)*NSAMP.
REQ-007 SHALL have port clk_i, input, 1, sole clock.
REQ-008 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port data_i, input, NCHAN x NSAMP*NBITS, per-channel word; sample 0 at LSBs, earliest in time.
REQ-010 SHALL have port data_valid_i, input, 1, qualifies data_i.
REQ-011 SHALL have ports dly_wr_i (1), dly_beam_i (clog2 NBEAMS), dly_chan_i (clog2 NCHAN), dly_val_i (DLY_W), inputs, shadow delay write.
REQ-012 SHALL have port dly_commit_i, input, 1, request shadow-to-active copy.
REQ-013 SHALL have port beams_o, output, NBEAMS x NCHAN x NSAMP*NBITS, aligned windows.
REQ-014 SHALL have port valid_o, output, 1, qualifies beams_o.
REQ-015 SHALL have ports commit_done_o (1-cycle pulse) and dly_err_o (sticky), outputs.

Function
REQ-016 Store SHALL shift one word per channel only on cycles with data_valid_i=1; otherwise hold.
REQ-017 For beam b, channel c, active delay d, output sample j of word k SHALL equal stream sample k*NSAMP+j-d of channel c.
REQ-018 With all delays 0, a word accepted at cycle N SHALL appear on beams_o with valid_o=1 at cycle N+2.
REQ-019 valid_o SHALL be 1 exactly one cycle after each accepted word once primed; else 0; beams_o registered and held when valid_o=0.
REQ-020 Priming: valid_o SHALL stay 0 until DEPTH words accepted since reset; 4-bit-wider saturating fill counter.
REQ-021 Delay write with dly_val_i > (DEPTH-1)*NSAMP, or beam/chan index out of range, SHALL be discarded and set dly_err_o until reset.
REQ-022 dly_commit_i SHALL arm a pending commit; copy to active SHALL occur on the next accepted word, never mid-window.
REQ-023 commit_done_o SHALL pulse 1 cycle, same cycle the first word using new delays is registered into beams_o.
REQ-024 dly_wr_i and dly_commit_i in the same cycle: write SHALL land in shadow and be included in that commit.
REQ-025 Repeat dly_commit_i while pending SHALL be absorbed (single commit, single pulse).
REQ-026 Write during pending commit (later cycle) SHALL also be included, since copy occurs at apply time.

Reset
REQ-027 rst_i SHALL clear shadow and active delays to 0, fill counter, pending flag, valid_o, commit_done_o, dly_err_o.
REQ-028 rst_i SHALL set every stored sample and beams_o sample to midscale 2^(NBITS-1).
REQ-029 rst_i mid-commit SHALL cancel the commit with no commit_done_o pulse.

Configuration
REQ-030 With BEAM_ALIGN_READBACK_EN defined, SHALL add output dly_rd_o (DLY_W), registered active delay at dly_beam_i/dly_chan_i, 1-cycle latency, reset 0.
REQ-031 Without BEAM_ALIGN_READBACK_EN, dly_rd_o SHALL not exist and no readback mux shall be built.

Structure
REQ-032 Package beam_align_pkg SHALL hold default parameters, delay_t typedef, MIDSCALE function, max-delay function.
REQ-033 Sub-module beam_delay_table SHALL own shadow/active tables, range check, pending/commit logic.
REQ-034 Window selection SHALL be a constant-width indexed part-select of the flattened store per beam/channel.

Verification
REQ-035 Reset, then 10 valid words of ramp (sample value = index mod 32) -> valid_o first at accept #10 +1 cycle, outputs match ramp, delay 0.
REQ-036 Write beam1 chan3 delay 13, commit -> after apply, beam1 chan3 sample j = ramp(k*8+j-13); commit_done_o one pulse.
REQ-037 Write delay 73 with DEPTH=10 -> write ignored, dly_err_o=1 until rst_i.
REQ-038 Commit with data_valid_i low 5 cycles -> no change or pulse until next valid word; output then uses new delay.
REQ-039 Assert rst_i with commit pending -> no pulse, delays 0, outputs 16, valid_o 0 until re-primed.
REQ-040 BEAM_ALIGN_READBACK_EN build: write 7, commit, read beam0 chan0 -> dly_rd_o=7 next cycle.
